// File: rtl/bcd_countdown.sv
// Four-digit MM:SS BCD countdown timer with pause/resume, expiry flag and
// blinking display enable once the count has run out.
module bcd_countdown #(
  parameter int unsigned TICK_DIV  = 125000000,
  parameter int unsigned BLINK_DIV = 62500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] disp_data,
  output logic        disp_en,
  output logic        running,
  output logic        expired,
  output logic        expire_pulse,
  output logic        load_err,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          disp_en_q, disp_en_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          pulse_q, pulse_d;
  logic          err_q, err_d;
  logic [15:0]   dec_val;
  logic          load_ok;

  assign load_ok = (load_val[15:12] <= 4'd9) && (load_val[11:8] <= 4'd9) &&
                   (load_val[7:4]   <= 4'd5) && (load_val[3:0]  <= 4'd9);

  // One-second borrow chain; only evaluated in RUN where the value is non-zero.
  always_comb begin
    dec_val = disp_q;
    if (disp_q[3:0] != 4'd0) begin
      dec_val[3:0] = disp_q[3:0] - 4'd1;
    end else begin
      dec_val[3:0] = 4'd9;
      if (disp_q[7:4] != 4'd0) begin
        dec_val[7:4] = disp_q[7:4] - 4'd1;
      end else begin
        dec_val[7:4] = 4'd5;
        if (disp_q[11:8] != 4'd0) begin
          dec_val[11:8] = disp_q[11:8] - 4'd1;
        end else begin
          dec_val[11:8]  = 4'd9;
          dec_val[15:12] = disp_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    disp_d    = disp_q;
    presc_d   = presc_q;
    blink_d   = blink_q;
    disp_en_d = disp_en_q;
    pulse_d   = 1'b0;
    err_d     = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      disp_d    = 16'h0000;
      presc_d   = '0;
      blink_d   = '0;
      disp_en_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            if (load_ok) disp_d = load_val;
            else         err_d  = 1'b1;
          end else if (start) begin
            if (disp_q != 16'h0000) begin
              state_d = S_RUN;
              presc_d = '0;
            end else begin
              state_d   = S_EXPIRED;
              pulse_d   = 1'b1;
              blink_d   = '0;
              disp_en_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          // Pause freezes the prescaler so a resume keeps the partial second.
          if (pause) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_TOP) begin
            presc_d = '0;
            disp_d  = dec_val;
            if (dec_val == 16'h0000) begin
              state_d   = S_EXPIRED;
              pulse_d   = 1'b1;
              blink_d   = '0;
              disp_en_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (start) state_d = S_RUN;
        end
        default: begin
          if (blink_q == BLINK_TOP) begin
            blink_d   = '0;
            disp_en_d = ~disp_en_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
      endcase
    end
    running_d = (state_d == S_RUN);
    expired_d = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      disp_q    <= 16'h0000;
      presc_q   <= '0;
      blink_q   <= '0;
      disp_en_q <= 1'b1;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      disp_en_q <= disp_en_d;
      running_q <= running_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  assign disp_data    = disp_q;
  assign disp_en      = disp_en_q;
  assign running      = running_q;
  assign expired      = expired_q;
  assign expire_pulse = pulse_q;
  assign load_err     = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: directed scenarios plus random commands, all
// checked against a seconds-based reference model of the timer.
module tb_bcd_countdown;

  localparam int TD = 4;
  localparam int BD = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] disp_data;
  logic        disp_en, running, expired, expire_pulse, load_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 expired; value kept in seconds.
  int   m_mode = 0, m_secs = 0, m_presc = 0, m_blink = 0;
  logic m_en = 1'b1, m_pulse = 1'b0, m_err = 1'b0;

  bcd_countdown #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .clear(clear), .disp_data(disp_data), .disp_en(disp_en),
    .running(running), .expired(expired), .expire_pulse(expire_pulse),
    .load_err(load_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sec2bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit legal(input logic [15:0] v);
    return v[15:12] <= 9 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9;
  endfunction

  function automatic int bcd2sec(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [22:0] model_vec();
    return {sec2bcd(m_secs), m_en, m_mode == 1, m_mode == 3, m_pulse, m_err, 2'(m_mode)};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {disp_data, disp_en, running, expired, expire_pulse, load_err, dbg_state};
  endfunction

  task automatic model_step(input logic ld, input logic [15:0] lv, input logic st,
                            input logic ps, input logic cl, input logic r);
    m_pulse = 1'b0;
    m_err   = 1'b0;
    if (r || cl) begin
      m_mode = 0; m_secs = 0; m_presc = 0; m_blink = 0; m_en = 1'b1;
    end else begin
      case (m_mode)
        0: begin
          if (ld) begin
            if (legal(lv)) m_secs = bcd2sec(lv);
            else           m_err = 1'b1;
          end else if (st) begin
            if (m_secs != 0) begin
              m_mode = 1; m_presc = 0;
            end else begin
              m_mode = 3; m_pulse = 1'b1; m_blink = 0; m_en = 1'b1;
            end
          end
        end
        1: begin
          if (ps) m_mode = 2;
          else if (m_presc == TD - 1) begin
            m_presc = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) begin
              m_mode = 3; m_pulse = 1'b1; m_blink = 0; m_en = 1'b1;
            end
          end else m_presc = m_presc + 1;
        end
        2: if (st) m_mode = 1;
        default: begin
          if (m_blink == BD - 1) begin
            m_blink = 0; m_en = ~m_en;
          end else m_blink = m_blink + 1;
        end
      endcase
    end
  endtask

  // Drive one cycle of commands, advance the model, sample 1 ns after the edge.
  task automatic cyc(input logic ld = 0, input logic [15:0] lv = 0, input logic st = 0,
                     input logic ps = 0, input logic cl = 0, input logic r = 0);
    load = ld; load_val = lv; start = st; pause = ps; clear = cl; rst = r;
    @(posedge clk);
    model_step(ld, lv, st, ps, cl, r);
    #1;
    load = 0; load_val = 0; start = 0; pause = 0; clear = 0; rst = 0;
  endtask

  task automatic test_reset();
    cyc(.r(1));
    n_cmp++;
    if (obs_vec() !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs_vec(), {16'h0000, 5'b10000, 2'd0});
    end
  endtask

  task automatic test_countdown();
    logic [15:0] seq [4];
    seq = '{16'h0101, 16'h0100, 16'h0059, 16'h0058};
    cyc(.ld(1), .lv(16'h0102));
    cyc(.st(1));
    n_cmp++;
    if (disp_data !== 16'h0102 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL countdown_start: got %h run %b want 0102 run 1", disp_data, running);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc();
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL countdown_cycle%0d: got %h want %h", i, obs_vec(), model_vec());
      end
      if (i % 4 == 0) begin
        n_cmp++;
        if (disp_data !== seq[i / 4 - 1] || running !== 1'b1) begin
          n_bad++;
          $display("FAIL countdown_tick%0d: got %h want %h", i / 4, disp_data, seq[i / 4 - 1]);
        end
      end
    end
    cyc(.cl(1));
  endtask

  task automatic test_expire();
    int pulses = 0;
    cyc(.ld(1), .lv(16'h0001));
    cyc(.st(1));
    for (int i = 0; i < 4; i++) cyc();
    n_cmp++;
    if (disp_data !== 16'h0000 || expired !== 1'b1 || expire_pulse !== 1'b1 || disp_en !== 1'b1) begin
      n_bad++;
      $display("FAIL expire_entry: got %h exp %b pulse %b en %b want 0000 1 1 1",
               disp_data, expired, expire_pulse, disp_en);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(.st(i % 2 == 1), .ps(i == 4), .ld(i == 6), .lv(16'h0300));
      pulses += int'(expire_pulse);
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL expire_blink%0d: got %h want %h", i, obs_vec(), model_vec());
      end
      if (i == 3) begin
        n_cmp++;
        if (disp_en !== 1'b0) begin
          n_bad++;
          $display("FAIL expire_first_toggle: got %b want 0", disp_en);
        end
      end
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL expire_pulse_width: got %0d extra want 0", pulses);
    end
    cyc(.cl(1));
    n_cmp++;
    if (disp_en !== 1'b1 || expired !== 1'b0 || disp_data !== 16'h0000 || dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL expire_clear: got en %b exp %b data %h st %0d want 1 0 0000 0",
               disp_en, expired, disp_data, dbg_state);
    end
  endtask

  task automatic test_load_err();
    logic [15:0] bad [2];
    bad = '{16'h0170, 16'h0A00};
    cyc(.ld(1), .lv(16'h0123));
    for (int i = 0; i < 2; i++) begin
      cyc(.ld(1), .lv(bad[i]));
      n_cmp++;
      if (load_err !== 1'b1 || disp_data !== 16'h0123) begin
        n_bad++;
        $display("FAIL load_err_%h: got err %b data %h want 1 0123", bad[i], load_err, disp_data);
      end
      cyc();
      n_cmp++;
      if (load_err !== 1'b0) begin
        n_bad++;
        $display("FAIL load_err_width_%h: got %b want 0", bad[i], load_err);
      end
    end
    cyc(.st(1));
    for (int i = 0; i < 3; i++) begin
      cyc(.ld(1), .lv(i == 1 ? 16'h0F00 : 16'h0250));
      n_cmp++;
      if (obs_vec() !== model_vec() || load_err !== 1'b0 || running !== 1'b1) begin
        n_bad++;
        $display("FAIL load_in_run%0d: got %h want %h", i, obs_vec(), model_vec());
      end
    end
    cyc(.cl(1));
  endtask

  task automatic test_pause();
    cyc(.ld(1), .lv(16'h0010));
    cyc(.st(1));
    cyc();
    cyc();
    cyc(.ps(1));
    for (int i = 0; i < 10; i++) cyc();
    n_cmp++;
    if (disp_data !== 16'h0010 || running !== 1'b0 || dbg_state !== 2'd2) begin
      n_bad++;
      $display("FAIL pause_hold: got %h run %b st %0d want 0010 0 2", disp_data, running, dbg_state);
    end
    cyc(.st(1));
    cyc();
    n_cmp++;
    if (disp_data !== 16'h0010 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_resume: got %h run %b want 0010 1", disp_data, running);
    end
    cyc();
    n_cmp++;
    if (disp_data !== 16'h0009) begin
      n_bad++;
      $display("FAIL pause_residual_tick: got %h want 0009", disp_data);
    end
    cyc(.st(1), .ps(1));
    n_cmp++;
    if (running !== 1'b0 || dbg_state !== 2'd2) begin
      n_bad++;
      $display("FAIL start_pause_in_run: got run %b st %0d want 0 2", running, dbg_state);
    end
    cyc(.st(1), .ps(1));
    n_cmp++;
    if (running !== 1'b1 || obs_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL start_pause_in_pause: got %h want %h", obs_vec(), model_vec());
    end
    cyc(.cl(1));
  endtask

  task automatic test_zero_start_clear();
    cyc(.st(1));
    n_cmp++;
    if (expired !== 1'b1 || expire_pulse !== 1'b1 || disp_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL zero_start: got exp %b pulse %b data %h want 1 1 0000",
               expired, expire_pulse, disp_data);
    end
    cyc(.cl(1), .ld(1), .lv(16'h0500));
    cyc();
    n_cmp++;
    if (disp_data !== 16'h0000 || expired !== 1'b0 || dbg_state !== 2'd0 || load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_over_load: got data %h exp %b st %0d want 0000 0 0", disp_data, expired, dbg_state);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
          {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 19) == 0) v = 16'h0000;
      if ($urandom_range(0, 29) == 0) v = 16'h9959;
      cyc(.ld($urandom_range(0, 7) == 0), .lv(v), .st($urandom_range(0, 3) == 0),
          .ps($urandom_range(0, 15) == 0), .cl($urandom_range(0, 63) == 0),
          .r($urandom_range(0, 199) == 0));
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL random%0d: got %h want %h", i, obs_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_expire();
    test_load_err();
    test_pause();
    test_zero_start_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
